combined_sample_axi_writer: RTL and testbench
=============================================

// Module: combined_sample_axi_writer
// PURPOSE
//  Consumes the combiner's packed I/Q sample stream (valid + data) and stores each sample
//  in on-chip SRAM through single-beat AXI4 write transactions.
//  Sits between the combiner output and the SRAM AXI slave port.
//  A small FIFO absorbs samples while a write is outstanding.
//  Addresses advance linearly through a circular capture window.
// PARAMETERS
//  DATA_W     32           width of combined sample and of AXI WDATA
//  ADDR_W     32           AXI address width
//  BASE_ADDR  32'h0000_0000  byte address of capture window word 0
//  NUM_WORDS  256          window length in words, power of 2, >=2
//  FIFO_DEPTH 8            sample FIFO depth, power of 2, >=2
// PORTS
//  clk            in   1          system clock, rising edge
//  reset          in   1          asynchronous, active-low: 0 = reset
//  din_valid      in   1          combined sample valid (no backpressure upstream)
//  din            in   DATA_W     combined I/Q sample
//  S_AXI_AWADDR   out  ADDR_W     write address
//  S_AXI_AWVALID  out  1          write address valid
//  S_AXI_AWREADY  in   1          slave address ready
//  S_AXI_WDATA    out  DATA_W     write data
//  S_AXI_WSTRB    out  DATA_W/8   always all ones
//  S_AXI_WVALID   out  1          write data valid
//  S_AXI_WREADY   in   1          slave data ready
//  S_AXI_BRESP    in   2          write response
//  S_AXI_BVALID   in   1          write response valid
//  S_AXI_BREADY   out  1          write response ready
//  word_idx       out  clog2(NUM_WORDS)  index of the next word to be written
//  frame_done     out  1          1-cycle pulse when the window wraps
//  overflow       out  1          sticky: a sample was dropped
//  resp_err       out  1          sticky: a BRESP[1]=1 response was received
// BEHAVIOUR
//  Reset (async assert, sync release): all VALIDs and BREADY = 0.
//   AWADDR = BASE_ADDR; WDATA = 0; word_idx = 0.
//   frame_done, overflow and resp_err = 0; FIFO emptied; FSM = IDLE.
//   Reset asserted mid-transaction aborts it immediately; the sample is lost.
//  FIFO:
//   Push when din_valid && (!full || pop in the same cycle).
//   din_valid while full with no pop drops the sample and sets overflow.
//  FSM, one outstanding transaction at a time:
//   IDLE: if FIFO not empty, pop the FIFO head into the WDATA register.
//    Also load AWADDR = BASE_ADDR + 4*word_idx, assert AWVALID and WVALID,
//    and go to ADDR_DATA.
//   ADDR_DATA: drop AWVALID on the cycle after AWVALID&&AWREADY.
//    Drop WVALID on the cycle after WVALID&&WREADY.
//    The two handshakes are independent and may complete in any order or together.
//    When both are done, assert BREADY and go to RESP.
//   RESP: on BVALID, drop BREADY and set resp_err if BRESP[1].
//    Increment word_idx modulo NUM_WORDS.
//    If word_idx was NUM_WORDS-1, pulse frame_done; go to IDLE.
//  VALID, once raised, is held with ADDR and DATA stable until accepted; it never
//   depends combinationally on READY.
//  Latency with READY and BVALID immediately high:
//   din_valid in cycle 0 -> AWVALID/WVALID high in cycle 2.
//   Steady-state throughput is 1 sample per 4 cycles; a longer burst overflows the FIFO.
//  An error response does not trigger a retry; word_idx still advances.
//  resp_err and overflow clear only on reset.
// STRUCTURE
//  qam_axi_defs.vh (shared include):
//   AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, FSM state encodings, WORD_BYTES = 4.
//  Sub-module sample_fifo: sync FIFO with full/empty, registered head, and push/pop on the same edge.
//  Top level holds the FSM, address/index counter and sticky flags.
// TESTING
//  Single sample 0xA5A5_1234, READY/BVALID always 1:
//   one AW/W at BASE_ADDR with WDATA 0xA5A5_1234; word_idx = 1; no flags.
//  AWREADY 3 cycles before WREADY, then the reverse order:
//   each VALID held until its own handshake; exactly one B accepted; AWADDR/WDATA stable throughout.
//  Burst of 12 back-to-back samples, FIFO_DEPTH=8, WREADY stalled 20 cycles:
//   overflow = 1; only the samples that fit are written, in order, to consecutive addresses.
//  NUM_WORDS=4, write 5 samples:
//   addresses 0x0, 0x4, 0x8, 0xC, 0x0; frame_done pulses once, after the 4th B.
//  BRESP = SLVERR on the 2nd write:
//   resp_err = 1 and stays set; the 3rd write goes to BASE_ADDR+8.
//  Reset pulled low with AWVALID high:
//   outputs reach reset values within the same cycle; after release the first write goes to BASE_ADDR.

Source files
------------

// File: rtl/combined_sample_axi_writer_pkg.sv
// Shared definitions for the combined-sample AXI writer: AXI response codes,
// writer FSM states and the word size of the capture window.
package combined_sample_axi_writer_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_RESP      = 2'd2
  } wr_state_e;

  // Slave and decode errors are the responses that mark the capture as bad.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:  return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/combined_sample_axi_writer_sample_fifo.sv
// Synchronous sample FIFO with same-edge push/pop; head is read straight from
// the storage registers so the writer can latch it on the pop edge.
module combined_sample_axi_writer_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head_c,
  output logic              full_c,
  output logic              empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  // Pointers carry one wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_c  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/combined_sample_axi_writer.sv
// Buffers combiner samples and writes each one to a circular SRAM capture
// window as a single-beat AXI4 write, one transaction outstanding at a time.
module combined_sample_axi_writer
  import combined_sample_axi_writer_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       NUM_WORDS  = 256,
  parameter int unsigned       FIFO_DEPTH = 8,
  localparam int unsigned      IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_valid,
  input  logic [DATA_W-1:0]   din,
  output logic [ADDR_W-1:0]   S_AXI_AWADDR,
  output logic                S_AXI_AWVALID,
  input  logic                S_AXI_AWREADY,
  output logic [DATA_W-1:0]   S_AXI_WDATA,
  output logic [DATA_W/8-1:0] S_AXI_WSTRB,
  output logic                S_AXI_WVALID,
  input  logic                S_AXI_WREADY,
  input  logic [1:0]          S_AXI_BRESP,
  input  logic                S_AXI_BVALID,
  output logic                S_AXI_BREADY,
  output logic [IDX_W-1:0]    word_idx,
  output logic                frame_done,
  output logic                overflow,
  output logic                resp_err
);

  wr_state_e         state_q, state_d;
  logic              pop_c, push_c;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  logic [ADDR_W-1:0] awaddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              awvalid_d, wvalid_d, bready_d;
  logic [IDX_W-1:0]  word_idx_d;
  logic              frame_done_d, overflow_d, resp_err_d;

  assign S_AXI_WSTRB = '1;

  // Upstream cannot be stalled, so a push is only refused when truly full.
  assign push_c = din_valid && (!fifo_full || pop_c);

  combined_sample_axi_writer_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .din     (din),
    .pop     (pop_c),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      S_AXI_AWADDR  <= BASE_ADDR;
      S_AXI_AWVALID <= 1'b0;
      S_AXI_WDATA   <= '0;
      S_AXI_WVALID  <= 1'b0;
      S_AXI_BREADY  <= 1'b0;
      word_idx      <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      state_q       <= state_d;
      S_AXI_AWADDR  <= awaddr_d;
      S_AXI_AWVALID <= awvalid_d;
      S_AXI_WDATA   <= wdata_d;
      S_AXI_WVALID  <= wvalid_d;
      S_AXI_BREADY  <= bready_d;
      word_idx      <= word_idx_d;
      frame_done    <= frame_done_d;
      overflow      <= overflow_d;
      resp_err      <= resp_err_d;
    end
  end

  // Next state: address and data phases both finish before the response phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_ADDR_DATA;
      ST_ADDR_DATA: if (!S_AXI_AWVALID && !S_AXI_WVALID) state_d = ST_RESP;
      ST_RESP:      if (S_AXI_BVALID) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    pop_c        = 1'b0;
    awaddr_d     = S_AXI_AWADDR;
    wdata_d      = S_AXI_WDATA;
    awvalid_d    = S_AXI_AWVALID;
    wvalid_d     = S_AXI_WVALID;
    bready_d     = S_AXI_BREADY;
    word_idx_d   = word_idx;
    frame_done_d = 1'b0;
    resp_err_d   = resp_err;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          wdata_d   = fifo_head;
          awaddr_d  = BASE_ADDR + ADDR_W'(word_idx) * ADDR_W'(WORD_BYTES);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      ST_ADDR_DATA: begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) awvalid_d = 1'b0;
        if (S_AXI_WVALID && S_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!S_AXI_AWVALID && !S_AXI_WVALID) bready_d = 1'b1;
      end
      ST_RESP: begin
        if (S_AXI_BVALID) begin
          bready_d     = 1'b0;
          resp_err_d   = resp_err | resp_is_err(S_AXI_BRESP);
          word_idx_d   = word_idx + IDX_W'(1);
          frame_done_d = (word_idx == IDX_W'(NUM_WORDS - 1));
        end
      end
      default: ;
    endcase
    overflow_d = overflow | (din_valid && fifo_full && !pop_c);
  end

endmodule

// File: tb/tb_combined_sample_axi_writer.sv
// Directed bench for combined_sample_axi_writer with a 4-word window at 0x1000
// and a scripted AXI slave whose ready/response levels each scenario sets.
module tb_combined_sample_axi_writer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [31:0] din;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [1:0]  word_idx;
  logic        frame_done, overflow, resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int          b_cnt, fd_cnt, stab_err;
  logic        aw_pend, w_pend;
  logic [31:0] aw_hold, w_hold;

  always #5 clk = ~clk;

  combined_sample_axi_writer #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .BASE_ADDR  (BASE),
    .NUM_WORDS  (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din_valid     (din_valid),
    .din           (din),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .word_idx      (word_idx),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .resp_err      (resp_err)
  );

  // Slave-side monitor: logs handshakes and flags VALID/payload changes before acceptance.
  always @(posedge clk) begin
    if (!reset) begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end else begin
      if (aw_pend && (!awvalid || awaddr != aw_hold)) stab_err++;
      if (w_pend && (!wvalid || wdata != w_hold)) stab_err++;
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready) w_q.push_back(wdata);
      if (bvalid && bready) b_cnt++;
      if (frame_done) fd_cnt++;
      aw_pend = awvalid && !awready;
      aw_hold = awaddr;
      w_pend  = wvalid && !wready;
      w_hold  = wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] aw_at(input int i);
    if (i < aw_q.size()) return aw_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] w_at(input int i);
    if (i < w_q.size()) return w_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    aw_q.delete();
    w_q.delete();
    b_cnt    = 0;
    fd_cnt   = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    bresp     = 2'b00;
    tick(2);
    clear_log();
    reset = 1'b1;
    tick(1);
  endtask

  task automatic send(input logic [31:0] d);
    din       = d;
    din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
  endtask

  task automatic wait_b(input int target, input string tag);
    int n = 0;
    while (b_cnt < target && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, 64'(b_cnt), 64'(target));
  endtask

  task automatic wait_aw(input string tag);
    int n = 0;
    while (!awvalid && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, 64'(awvalid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    aw_pend = 1'b0;
    w_pend  = 1'b0;
    clear_log();
    do_reset();

    // Reset state
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'(BASE));
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_word_idx", 64'(word_idx), 64'd0);
    check("rst_flags", 64'({frame_done, overflow, resp_err}), 64'd0);
    check("wstrb", 64'(wstrb), 64'hF);

    // Single sample, two-cycle latency to VALID
    send(32'hA5A5_1234);
    check("lat_cycle1_awvalid", 64'(awvalid), 64'd0);
    tick(1);
    check("lat_cycle2_valids", 64'({awvalid, wvalid}), 64'b11);
    check("lat_awaddr", 64'(awaddr), 64'(BASE));
    check("lat_wdata", 64'(wdata), 64'hA5A5_1234);
    wait_b(1, "single_b");
    check("single_aw", 64'(aw_at(0)), 64'(BASE));
    check("single_w", 64'(w_at(0)), 64'hA5A5_1234);
    check("single_word_idx", 64'(word_idx), 64'd1);
    check("single_bready_low", 64'(bready), 64'd0);
    check("single_flags", 64'({overflow, resp_err, 1'(fd_cnt != 0)}), 64'd0);

    // AW accepted 3 cycles before W, then the reverse
    do_reset();
    awready = 1'b0;
    wready  = 1'b0;
    send(32'h1111_2222);
    wait_aw("aw_first_valid");
    awready = 1'b1;
    tick(3);
    check("aw_first_after_aw", 64'({awvalid, wvalid}), 64'b01);
    check("aw_first_no_b", 64'(b_cnt), 64'd0);
    wready = 1'b1;
    wait_b(1, "aw_first_b");
    check("aw_first_addr", 64'(aw_at(0)), 64'(BASE));
    check("aw_first_data", 64'(w_at(0)), 64'h1111_2222);
    awready = 1'b0;
    wready  = 1'b0;
    send(32'h3333_4444);
    wait_aw("w_first_valid");
    wready = 1'b1;
    tick(3);
    check("w_first_after_w", 64'({awvalid, wvalid}), 64'b10);
    check("w_first_awaddr_held", 64'(awaddr), 64'(BASE + 32'd4));
    awready = 1'b1;
    wait_b(2, "w_first_b");
    tick(4);
    check("order_b_count", 64'(b_cnt), 64'd2);
    check("order_aw_count", 64'(aw_q.size()), 64'd2);
    check("w_first_addr", 64'(aw_at(1)), 64'(BASE + 32'd4));
    check("w_first_data", 64'(w_at(1)), 64'h3333_4444);
    check("order_stable", 64'(stab_err), 64'd0);

    // Burst of 12 with WREADY stalled: s0 in flight + 8 buffered, 3 dropped
    do_reset();
    awready = 1'b1;
    wready  = 1'b0;
    for (int i = 0; i < 12; i++) send(32'h100 + 32'(i));
    tick(8);
    check("burst_overflow", 64'(overflow), 64'd1);
    wready = 1'b1;
    wait_b(9, "burst_b");
    tick(10);
    check("burst_b_total", 64'(b_cnt), 64'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("burst_w%0d", i), 64'(w_at(i)), 64'(32'h100 + 32'(i)));
      check($sformatf("burst_aw%0d", i), 64'(aw_at(i)), 64'(BASE + 32'(4 * (i % 4))));
    end
    check("burst_word_idx", 64'(word_idx), 64'd1);
    check("burst_stable", 64'(stab_err), 64'd0);

    // Window wrap: 5 writes into a 4-word window
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(32'h200 + 32'(i));
      wait_b(i + 1, $sformatf("wrap_b%0d", i));
      check($sformatf("wrap_frame_done%0d", i), 64'(frame_done), 64'(i == 3));
    end
    tick(2);
    check("wrap_fd_count", 64'(fd_cnt), 64'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("wrap_aw%0d", i), 64'(aw_at(i)), 64'(BASE + 32'(4 * (i % 4))));
    check("wrap_word_idx", 64'(word_idx), 64'd1);

    // SLVERR on the second write
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bresp = (i == 1) ? 2'b10 : 2'b00;
      send(32'h300 + 32'(i));
      wait_b(i + 1, $sformatf("err_b%0d", i));
      check($sformatf("err_flag%0d", i), 64'(resp_err), 64'(i >= 1));
    end
    bresp = 2'b00;
    check("err_third_addr", 64'(aw_at(2)), 64'(BASE + 32'd8));
    tick(5);
    check("err_sticky", 64'(resp_err), 64'd1);

    // Reset asserted with AWVALID high
    do_reset();
    send(32'h400);
    wait_b(1, "mid_first_b");
    awready = 1'b0;
    wready  = 1'b0;
    send(32'h401);
    wait_aw("mid_awvalid");
    check("mid_awaddr", 64'(awaddr), 64'(BASE + 32'd4));
    #2 reset = 1'b0;
    #1;
    check("mid_async_valids", 64'({awvalid, wvalid, bready}), 64'd0);
    check("mid_async_awaddr", 64'(awaddr), 64'(BASE));
    check("mid_async_idx_wdata", 64'({word_idx, wdata}), 64'd0);
    @(negedge clk);
    clear_log();
    reset   = 1'b1;
    awready = 1'b1;
    wready  = 1'b1;
    tick(3);
    check("mid_sample_lost", 64'(aw_q.size()), 64'd0);
    send(32'h402);
    wait_b(1, "mid_after_b");
    tick(4);
    check("mid_after_addr", 64'(aw_at(0)), 64'(BASE));
    check("mid_after_data", 64'(w_at(0)), 64'h402);
    check("mid_after_count", 64'(aw_q.size()), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
